// File: rtl/acc_sample_fifo_if.sv
// Readout-side bundle of acc_sample_fifo: head sample, handshake and status flags.
// master = FIFO side (drives data/status), slave = consumer side (drives Dready).
interface acc_sample_fifo_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]          Dout;
  logic                      Dvalid;
  logic                      Dready;
  logic [$clog2(DEPTH):0]    Count;
  logic                      Full;
  logic                      Empty;
  logic                      Ovf;

  modport master (
    output Dout, Dvalid, Count, Full, Empty, Ovf,
    input  Dready
  );

  modport slave (
    input  Dout, Dvalid, Count, Full, Empty, Ovf,
    output Dready
  );
endinterface

// File: rtl/acc_sample_fifo.sv
// Decimates the accumulator output every PERIOD enabled cycles into a FWFT FIFO with sticky overflow.
// Define ACC_SAMPLE_DELTA_EN to push the difference from the previous sample instead of the raw value.
module acc_sample_fifo #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 4,
  parameter int PERIOD = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Ce,
  input  logic [WIDTH-1:0] Din,
  input  logic             Clr,
  acc_sample_fifo_if.master rd
);

  localparam int PW   = $clog2(DEPTH);
  localparam int NW   = PW + 1;
  localparam int CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST    = CW'(PERIOD - 1);
  localparam logic [NW-1:0] DEPTH_C = NW'(DEPTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             sample;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;
  logic [WIDTH-1:0] push_val;

  assign sample  = Ce && (cnt_q == LAST);
  assign full    = (count_q == DEPTH_C);
  assign pop     = (count_q != '0) && rd.Dready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the sample.
  assign push_ok = sample && (!full || pop);
  assign drop    = sample && full && !pop;

`ifdef ACC_SAMPLE_DELTA_EN
  logic [WIDTH-1:0] prev_q, prev_d;

  assign push_val = Din - prev_q;

  always_comb begin
    prev_d = prev_q;
    if (Clr)         prev_d = '0;
    else if (sample) prev_d = Din;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) prev_q <= '0;
    else      prev_q <= prev_d;
  end
`else
  assign push_val = Din;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    if (Clr) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (Ce) cnt_d = sample ? '0 : cnt_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_val;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (drop) ovf_d = 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign rd.Dvalid = (count_q != '0);
  assign rd.Dout   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign rd.Count  = count_q;
  assign rd.Full   = full;
  assign rd.Empty  = (count_q == '0);
  assign rd.Ovf    = ovf_q;

endmodule

// File: tb/tb_acc_sample_fifo.sv
// Directed bench for acc_sample_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the scenario checkpoints.
module tb_acc_sample_fifo;
  localparam int WIDTH  = 12;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             Ce = 1'b0;
  logic             Clr = 1'b0;
  logic [WIDTH-1:0] Din = '0;

  int nvec = 0;
  int nerr = 0;

  acc_sample_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  acc_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .CLK (clk),
    .RST (rst_n),
    .Ce  (Ce),
    .Din (Din),
    .Clr (Clr),
    .rd  (bus.master)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, sample events from a count of enabled edges.
  logic [WIDTH-1:0] q [$];
  bit               ovf_m  = 1'b0;
  int               ens    = 0;
  logic [WIDTH-1:0] prev_m = '0;

  always @(posedge clk or negedge rst_n) begin
    bit               do_pop;
    bit               do_samp;
    logic [WIDTH-1:0] v;
    if (!rst_n || Clr) begin
      q.delete();
      ovf_m  = 1'b0;
      ens    = 0;
      prev_m = '0;
    end else begin
      do_pop  = (q.size() > 0) && bus.Dready;
      do_samp = 1'b0;
      if (Ce) begin
        ens++;
        do_samp = (ens % PERIOD) == 0;
      end
      if (do_pop) void'(q.pop_front());
      if (do_samp) begin
`ifdef ACC_SAMPLE_DELTA_EN
        v      = Din - prev_m;
        prev_m = Din;
`else
        v = Din;
`endif
        if (q.size() < DEPTH) q.push_back(v);
        else                  ovf_m = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("model_dvalid", int'(bus.Dvalid), int'(n != 0));
    chk("model_dout",   int'(bus.Dout),   (n != 0) ? int'(q[0]) : 0);
    chk("model_count",  int'(bus.Count),  n);
    chk("model_full",   int'(bus.Full),   int'(n == DEPTH));
    chk("model_empty",  int'(bus.Empty),  int'(n == 0));
    chk("model_ovf",    int'(bus.Ovf),    int'(ovf_m));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.Dready = 1'b0;

    // Reset held with enable active and Din toggling.
    Ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Din = (i % 2 == 0) ? 12'h480 : 12'h000;
      @(negedge clk);
      chk("rst_count",  int'(bus.Count),  0);
      chk("rst_dvalid", int'(bus.Dvalid), 0);
      chk("rst_dout",   int'(bus.Dout),   0);
      chk("rst_empty",  int'(bus.Empty),  1);
      chk("rst_full",   int'(bus.Full),   0);
      chk("rst_ovf",    int'(bus.Ovf),    0);
    end
    step();
    rst_n = 1'b1;
    Din   = 12'h480;

    // First sample lands on the 8th enabled edge.
    steps(7);
    @(negedge clk);
    chk("first_not_yet", int'(bus.Count), 0);
    step();
    @(negedge clk);
    chk("first_count",  int'(bus.Count),  1);
    chk("first_dvalid", int'(bus.Dvalid), 1);
    chk("first_dout",   int'(bus.Dout),   12'h480);

    // Fill, overflow, then full push+pop on a sample edge.
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    for (int e = 1; e <= 48; e++) begin
      Din        = 12'(12'h100 + (e - 1) / 8 + 1);
      bus.Dready = (e == 48);
      step();
      if (e == 32) begin
        @(negedge clk);
        chk("fill_full",  int'(bus.Full),  1);
        chk("fill_count", int'(bus.Count), 4);
        chk("fill_ovf",   int'(bus.Ovf),   0);
      end
      if (e == 40) begin
        @(negedge clk);
        chk("ovf_set",   int'(bus.Ovf),   1);
        chk("ovf_count", int'(bus.Count), 4);
        chk("ovf_dout",  int'(bus.Dout),  12'h101);
      end
      if (e == 48) begin
        @(negedge clk);
        chk("fullpp_count", int'(bus.Count), 4);
        chk("fullpp_ovf",   int'(bus.Ovf),   1);
        chk("fullpp_dout",  int'(bus.Dout),  12'h102);
      end
    end
    bus.Dready = 1'b0;

    // Ce gaps shift the first push; Clr beats a coincident sample event.
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    @(negedge clk);
    chk("clr_count", int'(bus.Count), 0);
    chk("clr_ovf",   int'(bus.Ovf),   0);
    Din = 12'h2a5;
    steps(2);
    Ce = 1'b0;
    steps(3);
    Ce = 1'b1;
    steps(5);
    @(negedge clk);
    chk("gap_edge10", int'(bus.Count), 0);
    step();
    @(negedge clk);
    chk("gap_edge11",  int'(bus.Count), 1);
    chk("gap_dout",    int'(bus.Dout),  12'h2a5);
    steps(7);
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    @(negedge clk);
    chk("clr_samp_count", int'(bus.Count), 0);
    chk("clr_samp_ovf",   int'(bus.Ovf),   0);
    step();
    @(negedge clk);
    chk("clr_restart", int'(bus.Count), 0);

    // Two samples: raw or delta encoded.
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    Din = 12'h010;
    steps(8);
    Din = 12'h005;
    steps(8);
    @(negedge clk);
    chk("two_count", int'(bus.Count), 2);
    chk("two_head",  int'(bus.Dout),  12'h010);
    bus.Dready = 1'b1;
    step();
    bus.Dready = 1'b0;
    @(negedge clk);
`ifdef ACC_SAMPLE_DELTA_EN
    chk("two_second", int'(bus.Dout), 12'hff5);
`else
    chk("two_second", int'(bus.Dout), 12'h005);
`endif

    // Steady drain with concurrent pushes, then mixed Ce/Dready patterns.
    bus.Dready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      Din = 12'(i * 7 + 3);
      step();
    end
    for (int i = 0; i < 60; i++) begin
      Din        = 12'(12'h7f0 + i * 13);
      Ce         = (i % 5) != 2;
      bus.Dready = (i % 7) == 0 || (i % 7) == 3;
      step();
    end
    bus.Dready = 1'b0;
    Ce = 1'b1;
    steps(4);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
